rr_arbiter_fsm: RTL

- Round-robin arbiter that shares one downstream resource among N_REQ requesters.
- Uses a rotating-priority encoder to select a requester, then holds that grant until the resource signals completion or a hold timeout expires.
- Produces both a one-hot grant and its binary index, so the index can drive a downstream mux select directly.

---
 rtl/arb_pkg.sv | 11 +
 rtl/rr_priority_pick.sv | 33 +++
 rtl/rr_arbiter_fsm.sv | 87 ++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared arbiter types and pointer-wrap helper
package arb_pkg;

    typedef enum logic {IDLE, BUSY} arb_state_t;

    // Wraps explicitly so non-power-of-2 requester counts never leave the pointer out of range.
    function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// rtl/rr_priority_pick.sv - rotating-priority pick via double-width rotate-and-scan
module rr_priority_pick #(
    parameter int N_REQ = 8,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] win_idx,
    output logic [N_REQ-1:0] win_onehot
);

    logic [2*N_REQ-1:0] rot;

    always_comb begin
        int j;
        j       = 0;
        found   = 1'b0;
        win_idx = '0;
        rot     = {req, req} >> ptr;
        // Descending scan so the lowest offset from ptr is the last to assign.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                j = int'(ptr) + k;
                if (j >= N_REQ) j = j - N_REQ;
                found   = 1'b1;
                win_idx = IDX_W'(j);
            end
        end
        win_onehot = found ? (N_REQ'(1) << win_idx) : '0;
    end

endmodule

// File: rtl/rr_arbiter_fsm.sv
// rtl/rr_arbiter_fsm.sv - round-robin arbiter holding each grant until done or hold timeout
module rr_arbiter_fsm
    import arb_pkg::*;
#(
    parameter int N_REQ    = 8,
    parameter int IDX_W    = $clog2(N_REQ),
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = $clog2(MAX_HOLD + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid,
    output logic             timeout
);

    arb_state_t       state_q;
    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;
    logic [CNT_W-1:0] cnt_q;
    logic [N_REQ-1:0] grant_q;
    logic [IDX_W-1:0] idx_q;
    logic             timeout_q;

    logic             found;
    logic [IDX_W-1:0] win_idx;
    logic [N_REQ-1:0] win_onehot;

    rr_priority_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req        (req),
        .ptr        (ptr_q),
        .found      (found),
        .win_idx    (win_idx),
        .win_onehot (win_onehot)
    );

    assign ptr_d = IDX_W'(next_idx(32'(idx_q), N_REQ));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            cnt_q     <= '0;
            grant_q   <= '0;
            idx_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    timeout_q <= 1'b0;
                    if (found) begin
                        grant_q <= win_onehot;
                        idx_q   <= win_idx;
                        cnt_q   <= '0;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    // done takes precedence so a coincident completion never reports a timeout.
                    if (done || cnt_q == CNT_W'(MAX_HOLD - 1)) begin
                        grant_q   <= '0;
                        idx_q     <= '0;
                        cnt_q     <= '0;
                        ptr_q     <= ptr_d;
                        timeout_q <= ~done;
                        state_q   <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign grant       = grant_q;
    assign grant_idx   = idx_q;
    assign grant_valid = |grant_q;
    assign timeout     = timeout_q;

endmodule
